// File: rtl/instr_issue.sv
// In-order instruction issue queue feeding the super-ALU datapath.
// A per-register scoreboard holds back the head until its register sources have been written.
module instr_issue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WB_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [47:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_instr,
    input  logic        flush,
    output logic [4:0]  count,
    output logic        hazard,
    output logic [15:0] issued_cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [47:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [4:0]    r_count;
    logic [1:0]    r_sb [8];
    logic [15:0]   r_issued;

    logic [47:0]   w_head;
    logic          w_nonempty;
    logic          w_blocked;
    logic          w_push;
    logic          w_pop;
    logic [3:0]    w_src_busy;

    assign w_head     = r_mem[r_rptr];
    assign w_nonempty = (r_count != 5'd0);

    // A counter of 1 means the producer's write lands on this edge, so a dependent may issue
    // alongside it; this puts a consumer exactly WB_LAT cycles behind its producer.
    assign w_src_busy[0] = w_head[38] && (r_sb[w_head[32:30]] > 2'd1);
    assign w_src_busy[1] = w_head[29] && (r_sb[w_head[23:21]] > 2'd1);
    assign w_src_busy[2] = w_head[20] && (r_sb[w_head[14:12]] > 2'd1);
    assign w_src_busy[3] = w_head[11] && (r_sb[w_head[5:3]]   > 2'd1);
    assign w_blocked     = |w_src_busy;

    assign in_ready   = (r_count < 5'(DEPTH));
    assign out_valid  = w_nonempty && !w_blocked;
    assign hazard     = w_nonempty && w_blocked;
    assign out_instr  = w_nonempty ? w_head : 48'h0;
    assign count      = r_count;
    assign issued_cnt = r_issued;

    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= 5'd0;
            r_issued <= 16'd0;
            for (int i = 0; i < 8; i++) begin
                r_sb[i] <= 2'd0;
            end
        end else begin
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= 5'd0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 5'd1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 5'd1;
                end
            end

            if (w_pop) begin
                r_issued <= r_issued + 16'd1;
            end

            for (int i = 0; i < 8; i++) begin
                if (w_pop && (w_head[2:0] == 3'(i))) begin
                    r_sb[i] <= 2'(WB_LAT);
                end else if (r_sb[i] != 2'd0) begin
                    r_sb[i] <= r_sb[i] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: directed scenarios then random traffic, checked against a
// queue model where each register carries the cycle from which it may be read.
module tb_instr_issue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned WB_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [47:0] in_instr = 48'h0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] out_instr;
    logic        flush = 1'b0;
    logic [4:0]  count;
    logic        hazard;
    logic [15:0] issued_cnt;

    always #5 clk = ~clk;

    instr_issue #(
        .DEPTH (DEPTH),
        .WB_LAT(WB_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .flush     (flush),
        .count     (count),
        .hazard    (hazard),
        .issued_cnt(issued_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [47:0] m_q[$];
    int          m_ready[8];
    int          m_cyc = 0;
    logic [15:0] m_issued = 16'd0;

    function automatic logic [47:0] mk(input logic [2:0] dest, input logic r1s,
                                       input logic [7:0] n1);
        logic [47:0] w;
        w        = 48'h0;
        w[47:39] = 9'h1A5;
        w[38]    = r1s;
        w[37:30] = n1;
        w[2:0]   = dest;
        return w;
    endfunction

    function automatic bit reg_pending(input logic sel, input logic [2:0] r);
        return sel && (m_cyc < m_ready[r]);
    endfunction

    function automatic bit m_haz();
        logic [47:0] h;
        if (m_q.size() == 0) return 1'b0;
        h = m_q[0];
        return reg_pending(h[38], h[32:30]) || reg_pending(h[29], h[23:21]) ||
               reg_pending(h[20], h[14:12]) || reg_pending(h[11], h[5:3]);
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        bit hz;
        bit ne;
        hz = m_haz();
        ne = (m_q.size() != 0);
        chk("count", 48'(count), 48'(m_q.size()));
        chk("in_ready", 48'(in_ready), 48'(m_q.size() < DEPTH));
        chk("out_valid", 48'(out_valid), 48'(ne && !hz));
        chk("hazard", 48'(hazard), 48'(ne && hz));
        chk("out_instr", out_instr, ne ? m_q[0] : 48'h0);
        chk("issued_cnt", 48'(issued_cnt), 48'(m_issued));
    endtask

    // Called just after a rising edge: check, drive, clock, update the model.
    task automatic cycle(input logic iv, input logic [47:0] ii, input logic ordy,
                         input logic fl);
        bit          push;
        bit          pop;
        logic [47:0] hd;
        check_all();
        push      = iv && (m_q.size() < DEPTH) && !fl;
        pop       = !fl && ordy && (m_q.size() != 0) && !m_haz();
        in_valid  = iv;
        in_instr  = ii;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
        if (fl) begin
            m_q.delete();
        end else begin
            if (pop) begin
                hd = m_q.pop_front();
                m_ready[hd[2:0]] = m_cyc + int'(WB_LAT);
                m_issued++;
            end
            if (push) m_q.push_back(ii);
        end
        m_cyc++;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_count", 48'(count), 48'd0);
        chk("rst_out_valid", 48'(out_valid), 48'd0);
        chk("rst_in_ready", 48'(in_ready), 48'd1);
        chk("rst_hazard", 48'(hazard), 48'd0);
        chk("rst_out_instr", out_instr, 48'h0);
        chk("rst_issued", 48'(issued_cnt), 48'd0);
        m_q.delete();
        for (int i = 0; i < 8; i++) m_ready[i] = 0;
        m_issued = 16'd0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [47:0] a;
        logic [47:0] b;
        logic [47:0] w;
        for (int i = 0; i < 8; i++) m_ready[i] = 0;

        #3;
        chk("init_count", 48'(count), 48'd0);
        chk("init_in_ready", 48'(in_ready), 48'd1);
        chk("init_out_valid", 48'(out_valid), 48'd0);
        chk("init_hazard", 48'(hazard), 48'd0);
        chk("init_out_instr", out_instr, 48'h0);
        chk("init_issued", 48'(issued_cnt), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single instruction through an empty queue
        cycle(1'b1, 48'h0A0300C02020, 1'b0, 1'b0);
        chk("single_valid", 48'(out_valid), 48'd1);
        chk("single_instr", out_instr, 48'h0A0300C02020);
        cycle(1'b0, 48'h0, 1'b1, 1'b0);
        chk("single_issued", 48'(issued_cnt), 48'd1);
        chk("single_count", 48'(count), 48'd0);

        // RAW hazard on r0
        a = mk(3'd0, 1'b0, 8'h00);
        b = mk(3'd1, 1'b1, 8'h00);
        cycle(1'b1, a, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b1, 1'b0);
        chk("raw_hazard", 48'(hazard), 48'd1);
        chk("raw_blocked", 48'(out_valid), 48'd0);
        cycle(1'b0, 48'h0, 1'b1, 1'b0);
        chk("raw_clear", 48'(hazard), 48'd0);
        chk("raw_issuable", 48'(out_valid), 48'd1);
        cycle(1'b0, 48'h0, 1'b1, 1'b0);
        chk("raw_issued", 48'(issued_cnt), 48'd3);

        // Same pattern with an immediate operand
        b = mk(3'd1, 1'b0, 8'h00);
        cycle(1'b1, a, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b1, 1'b0);
        chk("imm_hazard", 48'(hazard), 48'd0);
        chk("imm_valid", 48'(out_valid), 48'd1);
        cycle(1'b0, 48'h0, 1'b1, 1'b0);
        chk("imm_issued", 48'(issued_cnt), 48'd5);

        // Fill to full, fifth push refused, no bypass on the pop cycle
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(3'(i + 4), 1'b0, 8'(i)), 1'b0, 1'b0);
        chk("full_count", 48'(count), 48'd4);
        chk("full_in_ready", 48'(in_ready), 48'd0);
        w = mk(3'd2, 1'b0, 8'h55);
        cycle(1'b1, w, 1'b0, 1'b0);
        cycle(1'b1, w, 1'b1, 1'b0);
        chk("full_ready_again", 48'(in_ready), 48'd1);
        chk("full_count_after_pop", 48'(count), 48'd3);
        cycle(1'b1, w, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 48'h0, 1'b1, 1'b0);

        // Flush with a simultaneous push at count=3
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(3'(i), 1'b0, 8'h11), 1'b0, 1'b0);
        cycle(1'b1, mk(3'd7, 1'b0, 8'h22), 1'b1, 1'b1);
        chk("flush_count", 48'(count), 48'd0);
        chk("flush_valid", 48'(out_valid), 48'd0);
        cycle(1'b0, 48'h0, 1'b0, 1'b0);

        // Asynchronous reset in mid-cycle with two entries queued
        cycle(1'b1, mk(3'd1, 1'b0, 8'h01), 1'b0, 1'b0);
        cycle(1'b1, mk(3'd2, 1'b0, 8'h02), 1'b0, 1'b0);
        mid_reset();
        cycle(1'b1, mk(3'd3, 1'b0, 8'h03), 1'b0, 1'b0);
        chk("post_reset_push", 48'(count), 48'd1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            w = {16'($urandom()), 32'($urandom())};
            cycle(($urandom_range(0, 99) < 60), w, ($urandom_range(0, 99) < 75),
                  ($urandom_range(0, 99) < 2));
            if (n == 300) mid_reset();
        end
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
